icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl.sv | 160 ++++++++++++++++
 tb/tb_icache_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped flop-based instruction cache controller with single-line fill
// Optional hit/miss performance counters are built only when ICACHE_PERF_CNT_EN is defined.
module icache_ctrl #(
    parameter int IDX_W = 5
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_addr_valid,
    input  logic        inv_all,
    output logic [63:0] cache_line,
    output logic [14:0] cache_addr_ret,
    output logic        cache_line_valid,
    output logic        mem_rd_req,
    output logic [14:0] mem_rd_addr,
    input  logic        mem_rd_gnt,
    input  logic        mem_rd_valid,
    input  logic [63:0] mem_rd_data,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int SETS  = 1 << IDX_W;
    localparam int TAG_W = 12 - IDX_W;

    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, FILL} state_t;

    state_t             state_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [63:0]        data_q [SETS];
    logic [14:0]        miss_addr_q;
    logic               kill_q;
    logic [63:0]        cache_line_q;
    logic [14:0]        cache_addr_ret_q;
    logic               cache_line_valid_q;
    logic               mem_rd_req_q;
    logic [14:0]        mem_rd_addr_q;

    logic [IDX_W-1:0]   fetch_idx;
    logic [TAG_W-1:0]   fetch_tag;
    logic [IDX_W-1:0]   miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               hit;
    logic               req_ok;
    logic               hit_evt;
    logic               miss_evt;
    logic               fill_we;
    logic               unused_fetch_hi;

    assign fetch_idx = fetch_addr[IDX_W+2:3];
    assign fetch_tag = fetch_addr[14:IDX_W+3];
    assign miss_idx  = miss_addr_q[IDX_W+2:3];
    assign miss_tag  = miss_addr_q[14:IDX_W+3];
    assign hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    // An invalidate in IDLE swallows the request entirely: no hit response, no miss.
    assign req_ok   = (state_q == IDLE) && fetch_addr_valid && !inv_all;
    assign hit_evt  = req_ok && hit;
    assign miss_evt = req_ok && !hit;
    assign fill_we  = (state_q == MWAIT) && mem_rd_valid && !reset;

    assign unused_fetch_hi = ^fetch_addr[31:15];

    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= mem_rd_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q            <= IDLE;
            valid_q            <= '0;
            kill_q             <= 1'b0;
            miss_addr_q        <= '0;
            cache_line_q       <= '0;
            cache_addr_ret_q   <= '0;
            cache_line_valid_q <= 1'b0;
            mem_rd_req_q       <= 1'b0;
            mem_rd_addr_q      <= '0;
        end else begin
            cache_line_valid_q <= 1'b0;
            // A fill racing an invalidate (now or earlier in this miss) lands with valid=0.
            if (inv_all) begin
                valid_q <= '0;
            end else if (fill_we) begin
                valid_q[miss_idx] <= !kill_q;
            end
            case (state_q)
                IDLE: begin
                    if (hit_evt) begin
                        cache_line_q       <= data_q[fetch_idx];
                        cache_addr_ret_q   <= fetch_addr[14:0];
                        cache_line_valid_q <= 1'b1;
                    end else if (miss_evt) begin
                        miss_addr_q   <= fetch_addr[14:0];
                        mem_rd_addr_q <= {fetch_addr[14:3], 3'b000};
                        mem_rd_req_q  <= 1'b1;
                        kill_q        <= 1'b0;
                        state_q       <= MREQ;
                    end
                end
                MREQ: begin
                    if (inv_all) kill_q <= 1'b1;
                    if (mem_rd_gnt) begin
                        mem_rd_req_q <= 1'b0;
                        state_q      <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (inv_all) kill_q <= 1'b1;
                    if (mem_rd_valid) begin
                        cache_line_q       <= mem_rd_data;
                        cache_addr_ret_q   <= miss_addr_q;
                        cache_line_valid_q <= 1'b1;
                        state_q            <= FILL;
                    end
                end
                default: begin
                    kill_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cache_line       = cache_line_q;
    assign cache_addr_ret   = cache_addr_ret_q;
    assign cache_line_valid = cache_line_valid_q;
    assign mem_rd_req       = mem_rd_req_q;
    assign mem_rd_addr      = mem_rd_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] hit_cnt_d;
    logic [15:0] miss_cnt_q;
    logic [15:0] miss_cnt_d;

    assign hit_cnt_d  = (hit_evt && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
    assign miss_cnt_d = (miss_evt && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 16'h0000;
    assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed self-checking bench for icache_ctrl
module tb_icache_ctrl;
    logic        CLK;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_addr_valid;
    logic        inv_all;
    logic [63:0] cache_line;
    logic [14:0] cache_addr_ret;
    logic        cache_line_valid;
    logic        mem_rd_req;
    logic [14:0] mem_rd_addr;
    logic        mem_rd_gnt;
    logic        mem_rd_valid;
    logic [63:0] mem_rd_data;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_vec;
    int n_err;

`ifdef ICACHE_PERF_CNT_EN
    localparam logic [15:0] EXP_HIT_034  = 16'd2;
    localparam logic [15:0] EXP_MISS_034 = 16'd1;
    localparam logic [15:0] EXP_MISS_END = 16'd1;
`else
    localparam logic [15:0] EXP_HIT_034  = 16'd0;
    localparam logic [15:0] EXP_MISS_034 = 16'd0;
    localparam logic [15:0] EXP_MISS_END = 16'd0;
`endif

    icache_ctrl #(.IDX_W(5)) dut (
        .CLK              (CLK),
        .reset            (reset),
        .fetch_addr       (fetch_addr),
        .fetch_addr_valid (fetch_addr_valid),
        .inv_all          (inv_all),
        .cache_line       (cache_line),
        .cache_addr_ret   (cache_addr_ret),
        .cache_line_valid (cache_line_valid),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_gnt       (mem_rd_gnt),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_data      (mem_rd_data),
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fetch_addr = '0; fetch_addr_valid = 1'b0; inv_all = 1'b0;
        mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        step(); step();
        n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL rst_clv got %0b want 0", cache_line_valid); end
        n_vec++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b want 0", mem_rd_req); end
        n_vec++; if (cache_line !== 64'h0) begin n_err++; $display("FAIL rst_line got %h want 0", cache_line); end
        n_vec++; if (cache_addr_ret !== 15'h0) begin n_err++; $display("FAIL rst_ret got %h want 0", cache_addr_ret); end
        n_vec++; if (mem_rd_addr !== 15'h0) begin n_err++; $display("FAIL rst_rdaddr got %h want 0", mem_rd_addr); end
        n_vec++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
        reset = 1'b0;
        step();
    endtask

    // Caller is at #1 after an edge with the FSM in IDLE; returns the same way.
    task automatic test_miss_fill(input logic [14:0] addr, input logic [63:0] data,
                                  input int vld_delay, input bit inv_wait);
        fetch_addr = {17'h0, addr}; fetch_addr_valid = 1'b1;
        step();
        fetch_addr_valid = 1'b0;
        n_vec++; if (mem_rd_req !== 1'b1) begin n_err++; $display("FAIL miss_req addr %h got %0b want 1", addr, mem_rd_req); end
        n_vec++; if (mem_rd_addr !== {addr[14:3], 3'b000}) begin n_err++; $display("FAIL miss_rdaddr got %h want %h", mem_rd_addr, {addr[14:3], 3'b000}); end
        n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL miss_noresp got %0b want 0", cache_line_valid); end
        mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0;
        n_vec++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL gnt_drop got %0b want 0", mem_rd_req); end
        inv_all = inv_wait;
        for (int i = 0; i < vld_delay - 1; i++) begin
            step();
            inv_all = 1'b0;
            n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL wait_clv got %0b want 0", cache_line_valid); end
        end
        inv_all = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = data;
        step();
        mem_rd_valid = 1'b0;
        n_vec++; if (cache_line_valid !== 1'b1) begin n_err++; $display("FAIL fill_clv got %0b want 1", cache_line_valid); end
        n_vec++; if (cache_line !== data) begin n_err++; $display("FAIL fill_line got %h want %h", cache_line, data); end
        n_vec++; if (cache_addr_ret !== addr) begin n_err++; $display("FAIL fill_ret got %h want %h", cache_addr_ret, addr); end
        step();
        n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL fill_onecyc got %0b want 0", cache_line_valid); end
    endtask

    task automatic test_hit(input logic [14:0] addr, input logic [63:0] data);
        fetch_addr = {17'h0, addr}; fetch_addr_valid = 1'b1;
        step();
        fetch_addr_valid = 1'b0;
        n_vec++; if (cache_line_valid !== 1'b1 || cache_addr_ret !== addr) begin n_err++; $display("FAIL hit got clv %0b ret %h want 1 %h", cache_line_valid, cache_addr_ret, addr); end
        n_vec++; if (cache_line !== data) begin n_err++; $display("FAIL hit_line got %h want %h", cache_line, data); end
        step();
        n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL hit_onecyc got %0b want 0", cache_line_valid); end
    endtask

    task automatic test_back_to_back();
        fetch_addr = 32'h0125; fetch_addr_valid = 1'b1;
        step();
        fetch_addr = 32'h0121;
        n_vec++; if (cache_line_valid !== 1'b1 || cache_addr_ret !== 15'h0125) begin n_err++; $display("FAIL b2b_first got clv %0b ret %h want 1 0125", cache_line_valid, cache_addr_ret); end
        n_vec++; if (cache_line !== 64'h1122334455667788) begin n_err++; $display("FAIL b2b_first_line got %h want 1122334455667788", cache_line); end
        n_vec++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL b2b_noreq1 got %0b want 0", mem_rd_req); end
        step();
        fetch_addr_valid = 1'b0;
        n_vec++; if (cache_line_valid !== 1'b1 || cache_addr_ret !== 15'h0121) begin n_err++; $display("FAIL b2b_second got clv %0b ret %h want 1 0121", cache_line_valid, cache_addr_ret); end
        n_vec++; if (cache_line !== 64'h1122334455667788) begin n_err++; $display("FAIL b2b_second_line got %h want 1122334455667788", cache_line); end
        n_vec++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL b2b_noreq2 got %0b want 0", mem_rd_req); end
        step();
        n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %0b want 0", cache_line_valid); end
        n_vec++; if (hit_cnt !== EXP_HIT_034 || miss_cnt !== EXP_MISS_034) begin n_err++; $display("FAIL perf_cnt got hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, EXP_HIT_034, EXP_MISS_034); end
    endtask

    task automatic test_inv_idle();
        fetch_addr = 32'h0127; fetch_addr_valid = 1'b1; inv_all = 1'b1;
        step();
        fetch_addr_valid = 1'b0; inv_all = 1'b0;
        n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL inv_idle_suppress got %0b want 0", cache_line_valid); end
        n_vec++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL inv_idle_noreq got %0b want 0", mem_rd_req); end
        test_miss_fill(15'h0127, 64'hCAFEF00D12345678, 2, 1'b0);
    endtask

    task automatic test_reset_mid_miss();
        fetch_addr = 32'h0300; fetch_addr_valid = 1'b1;
        step();
        fetch_addr_valid = 1'b0; mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 64'hDEADBEEFDEADBEEF;
        step();
        mem_rd_valid = 1'b0;
        n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL rstmiss_noresp got %0b want 0", cache_line_valid); end
        n_vec++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL rstmiss_noreq got %0b want 0", mem_rd_req); end
        step();
        n_vec++; if (cache_line_valid !== 1'b0) begin n_err++; $display("FAIL rstmiss_noresp2 got %0b want 0", cache_line_valid); end
        test_miss_fill(15'h0200, 64'h0F0F0F0F0F0F0F0F, 1, 1'b0);
        n_vec++; if (miss_cnt !== EXP_MISS_END || hit_cnt !== 16'h0) begin n_err++; $display("FAIL perf_after_rst got hit %0d miss %0d want 0 %0d", hit_cnt, miss_cnt, EXP_MISS_END); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_miss_fill(15'h0123, 64'h1122334455667788, 3, 1'b0);
        test_back_to_back();
        test_miss_fill(15'h1120, 64'hAAAA5555AAAA5555, 2, 1'b0);
        test_miss_fill(15'h0120, 64'h0102030405060708, 1, 1'b0);
        test_hit(15'h0127, 64'h0102030405060708);
        test_inv_idle();
        test_miss_fill(15'h0200, 64'h9999888877776666, 3, 1'b1);
        test_miss_fill(15'h0200, 64'h5555666677778888, 1, 1'b0);
        test_hit(15'h0204, 64'h5555666677778888);
        test_reset_mid_miss();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
